imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader directly upstream of the single-cycle RISC core. It accepts a byte stream over a valid/ready handshake, checks a length header, assembles little-endian 32-bit instruction words and writes them into instruction memory from address 0. After a trailing XOR checksum byte matches, it releases the core by asserting `core_run`. A checksum mismatch or an illegal length leaves the core held and raises `load_err`.

## Interface
- `ADDR_W`, 11: instruction memory address width, matching the core's 11-bit PC.
- `MAX_WORDS`, 2048: largest legal word count. Must be ≤ 2^ADDR_W.
- `clk  in  1`: single clock, all state updates on the rising edge.
- `reset  in  1`: asynchronous, active-low reset.
- `rx_data  in  8`: incoming stream byte.
- `rx_valid  in  1`: `rx_data` is valid.
- `rx_ready  out  1`: loader can accept a byte. A byte transfers on a rising edge with `rx_valid & rx_ready`.
- `restart  in  1`: synchronous request to begin a new load. Honoured only in DONE or ERR.
- `imem_we  out  1`: instruction memory write strobe, one-cycle pulse.
- `imem_addr  out  ADDR_W`: word write address.
- `imem_wdata  out  32`: instruction word to write.
- `core_run  out  1`: core reset release. 1 means the core may execute.
- `load_err  out  1`: load failed.
- `busy  out  1`: a load is in progress.

## Operation
- FSM states: HDR_LO, HDR_HI, PAYLOAD, CHECK, DONE, ERR.
- HDR_LO: the accepted byte becomes count[7:0], then go to HDR_HI.
- HDR_HI: the accepted byte becomes count[15:8].
  - If count is 0 or greater than `MAX_WORDS`, go to ERR.
  - Otherwise go to PAYLOAD.
- PAYLOAD: byte index 0–3 cycles through each word.
  - The first byte goes to bits [7:0] and the fourth to bits [31:24].
  - Every payload byte is XORed into an 8-bit checksum register (cleared to 0 on entry). Header bytes are excluded.
  - On acceptance of the 4th byte of a word, the registered write fires (`imem_we`, `imem_addr`, `imem_wdata`).
  - The word address starts at 0 and increments after each write.
  - After the 4th byte of word count−1, go to CHECK.
- CHECK: the accepted byte is compared with the checksum register.
  - Equal: go to DONE.
  - Not equal: go to ERR.
- DONE: `core_run`=1.
- ERR: `load_err`=1.
- DONE/ERR with `restart`=1: go to HDR_LO. This clears `core_run`, `load_err`, the checksum, the byte index and the address. `restart` is ignored in all other states.
- `rx_ready` = 1 in HDR_LO, HDR_HI, PAYLOAD and CHECK. It is 0 in DONE and ERR, and 0 while `reset` is low.
- `busy` = 1 in HDR_HI, PAYLOAD and CHECK only.
- Bytes presented while `rx_ready`=0 are not consumed. The loader never drops or reorders accepted bytes.
- Instruction memory contents are never cleared by the loader.

## Timing
- Reset (`reset` low, async): the following take effect immediately and hold until the first edge after release:
  - state = HDR_LO.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `core_run`=0, `load_err`=0, `busy`=0, `rx_ready`=0.
  - checksum, count and byte index = 0.
- Reset mid-load: the partial word is discarded and no further write occurs. Words already written stay in memory.
- Throughput: one byte per cycle, with no stall cycles between header, payload and checksum.
- Write latency: 4th byte accepted at edge k → `imem_we`=1 during cycle k..k+1 only, with address and data stable for that cycle.
  - `imem_addr` increments at edge k+1 and then holds.
  - The checksum byte may be accepted at edge k+1, concurrently with the final write pulse.
- `core_run`/`load_err` rise on the edge that accepts the checksum byte (or the 2nd header byte, for an illegal count). `rx_ready` falls on the same edge.
- Restart: `restart` sampled high at edge r in DONE/ERR → at edge r: state = HDR_LO, `core_run`=0, `load_err`=0, `rx_ready`=1.
- When count = `MAX_WORDS`, the address reaches 2^ADDR_W after the last write and wraps to 0. No write follows, so the wrap is harmless.

## Test plan
- Minimal load:
  - Stimulus: stream 01 00 78 56 34 12 08 with `rx_valid` held high.
  - Required: exactly one write, addr 0, data 0x12345678. `core_run`=1 the cycle after the 08 byte is accepted. `load_err`=0, `rx_ready`=0.
- Zero count:
  - Stimulus: stream 00 00.
  - Required: ERR after the 2nd byte, `load_err`=1, no `imem_we` pulse, `core_run` stays 0.
- Oversize count:
  - Stimulus: stream 01 08 (2049).
  - Required: ERR immediately and no writes. Any following bytes are not accepted.
- Full load with backpressure:
  - Stimulus: count 00 08, 8192 payload bytes plus the correct checksum, `rx_valid` randomly toggled.
  - Required: 2048 writes to addr 0..2047 in order with correct data, then `core_run`=1.
- Bad checksum then restart:
  - Stimulus: the minimal stream with checksum 09, then a 1-cycle `restart`, then the correct stream.
  - Required: first pass gives `load_err`=1 and `core_run`=0. After restart, `load_err`=0 and the second pass gives `core_run`=1.
- Reset mid-payload:
  - Stimulus: drop `reset` after header 02 00 plus 6 payload bytes, then reload 01 00 78 56 34 12 08.
  - Required: outputs go to reset values asynchronously, and exactly one write (addr 0, word 0) occurs before the reset. After reset, a single write to addr 0 of 0x12345678, then `core_run`=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes little-endian
// instruction words from address 0, and releases the core once the XOR checksum matches.
module imem_loader #(
    parameter int ADDR_W    = 11,
    parameter int MAX_WORDS = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_run,
    output logic              load_err,
    output logic              busy,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        HDR_LO  = 3'd0,
        HDR_HI  = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } state_t;

    localparam logic [16:0] MAX_COUNT = 17'(MAX_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic        rx_armed;
    logic [15:0] count;
    logic [1:0]  byte_idx;
    logic [7:0]  checksum;
    logic [23:0] word_buf;

    logic        accept;
    logic [15:0] hdr_count;
    logic        hdr_bad;
    logic        last_word;

    // Handshake: a byte moves on a rising edge where rx_valid & rx_ready are both
    // high; the sender holds rx_data steady until then, and rx_ready never looks at rx_valid.
    assign accept    = rx_valid & rx_ready;
    assign hdr_count = {rx_data, count[7:0]};
    assign hdr_bad   = (hdr_count == 16'd0) || ({1'b0, hdr_count} > MAX_COUNT);
    // imem_addr still holds the index of the word being completed at its 4th byte.
    assign last_word = (16'(imem_addr) == (count - 16'd1));
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HDR_LO;
        end else begin
            state <= state_nxt;
        end
    end

    // rx_ready stays low through reset and the first edge after its release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_armed <= 1'b0;
        end else begin
            rx_armed <= 1'b1;
        end
    end

    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        core_run = 1'b0;
        load_err = 1'b0;
        case (state)
            HDR_LO:  rx_ready = rx_armed;
            HDR_HI:  begin rx_ready = rx_armed; busy = 1'b1; end
            PAYLOAD: begin rx_ready = rx_armed; busy = 1'b1; end
            CHECK:   begin rx_ready = rx_armed; busy = 1'b1; end
            DONE:    core_run = 1'b1;
            ERR:     load_err = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HDR_LO: begin
                if (accept) state_nxt = HDR_HI;
            end
            HDR_HI: begin
                if (accept) state_nxt = hdr_bad ? ERR : PAYLOAD;
            end
            PAYLOAD: begin
                if (accept && (byte_idx == 2'd3) && last_word) state_nxt = CHECK;
            end
            CHECK: begin
                if (accept) state_nxt = (rx_data == checksum) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (restart) state_nxt = HDR_LO;
            end
            default: state_nxt = HDR_LO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= 16'd0;
            byte_idx   <= 2'd0;
            checksum   <= 8'd0;
            word_buf   <= 24'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            if (imem_we) imem_addr <= imem_addr + 1'b1;
            case (state)
                HDR_LO: begin
                    if (accept) count[7:0] <= rx_data;
                end
                HDR_HI: begin
                    if (accept) begin
                        count[15:8] <= rx_data;
                        checksum    <= 8'd0;
                        byte_idx    <= 2'd0;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        checksum <= checksum ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {rx_data, word_buf};
                            end
                        endcase
                    end
                end
                DONE, ERR: begin
                    if (restart) begin
                        count     <= 16'd0;
                        byte_idx  <= 2'd0;
                        checksum  <= 8'd0;
                        imem_addr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts every output each
// cycle, and literal expectations pin the main scenarios.
module tb_imem_loader;

    localparam int ADDR_W    = 11;
    localparam int MAX_WORDS = 2048;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic [7:0]        rx_data  = 8'd0;
    logic              rx_valid = 1'b0;
    logic              restart  = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_run;
    logic              load_err;
    logic              busy;
    logic [2:0]        state_dbg;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_run   (core_run),
        .load_err   (load_err),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stream-level model: what has been accepted in the current load.
    int          m_acc   = 0;
    logic [15:0] m_cnt   = 16'd0;
    logic [7:0]  m_csum  = 8'd0;
    logic [31:0] m_word  = 32'd0;
    logic        m_ready = 1'b0;
    logic        m_busy  = 1'b0;
    logic        m_run   = 1'b0;
    logic        m_err   = 1'b0;
    int          m_we_at = -1;
    int          m_waddr = 0;
    logic [31:0] m_wdata = 32'd0;

    int          cyc      = 0;
    int          n_writes = 0;
    logic [ADDR_W-1:0] last_waddr = '0;
    logic [31:0]       last_wdata = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        m_acc  = 0;
        m_cnt  = 16'd0;
        m_csum = 8'd0;
        m_word = 32'd0;
        m_busy = 1'b0;
        m_run  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        int n;
        m_acc++;
        n = int'(m_cnt);
        if (m_acc == 1) begin
            m_cnt[7:0] = b;
            m_busy = 1'b1;
        end else if (m_acc == 2) begin
            m_cnt[15:8] = b;
            m_csum = 8'd0;
            if (m_cnt == 16'd0 || int'(m_cnt) > MAX_WORDS) begin
                m_err = 1'b1; m_busy = 1'b0; m_ready = 1'b0;
            end
        end else if (m_acc <= 2 + 4 * n) begin
            m_csum = m_csum ^ b;
            m_word = {b, m_word[31:8]};
            if ((m_acc - 2) % 4 == 0) begin
                m_we_at = cyc;
                m_waddr = (m_acc - 3) / 4;
                m_wdata = m_word;
            end
        end else begin
            m_busy = 1'b0; m_ready = 1'b0;
            if (b == m_csum) m_run = 1'b1;
            else             m_err = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        check("rx_ready", 32'(rx_ready), 32'(m_ready));
        check("busy",     32'(busy),     32'(m_busy));
        check("core_run", 32'(core_run), 32'(m_run));
        check("load_err", 32'(load_err), 32'(m_err));
        check("imem_we",  32'(imem_we),  32'(m_we_at == cyc));
        if (imem_we && (m_we_at == cyc)) begin
            check("imem_addr",  32'(imem_addr), 32'(m_waddr % (1 << ADDR_W)));
            check("imem_wdata", imem_wdata,     m_wdata);
        end
        if (!reset) begin
            check("rst_addr",  32'(imem_addr), 32'd0);
            check("rst_wdata", imem_wdata,     32'd0);
        end
        if (imem_we) begin
            n_writes++;
            last_waddr = imem_addr;
            last_wdata = imem_wdata;
        end
        cyc++;
    end

    task automatic send_byte(input logic [7:0] b, input int gaps, input int max_wait, output logic acc);
        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        acc = 1'b0;
        for (int w = 0; w < max_wait; w++) begin
            if (rx_ready) begin
                @(posedge clk);
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (acc) model_accept(b);
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit bp);
        logic acc;
        foreach (s[i]) begin
            send_byte(s[i], bp ? int'($urandom_range(0, 1)) : 0, 64, acc);
            if (!acc) begin
                n_tests++;
                n_fail++;
                $display("FAIL stream_accept: byte %0d not taken in 64 cycles (state_dbg %0d), required accepted", i, state_dbg);
                break;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_clear();
        m_ready = 1'b0;
        m_we_at = -1;
        #1;
        check("async_rx_ready", 32'(rx_ready), 32'd0);
        check("async_busy",     32'(busy),     32'd0);
        check("async_core_run", 32'(core_run), 32'd0);
        check("async_load_err", 32'(load_err), 32'd0);
        check("async_imem_we",  32'(imem_we),  32'd0);
        check("async_addr",     32'(imem_addr), 32'd0);
        check("async_wdata",    imem_wdata,    32'd0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        m_ready = 1'b1;
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        if (m_run || m_err) begin
            model_clear();
            m_ready = 1'b1;
        end
        #1;
        restart = 1'b0;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] full_word(input int i);
        return 32'(i) * 32'h9E3779B9 + 32'h01234567;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  q[$];
        logic [7:0]  cs;
        logic [31:0] w;
        logic        acc;
        int          w0;

        apply_reset();

        // Minimal load, rx_valid held high.
        q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        w0 = n_writes;
        send_stream(q, 1'b0);
        check("min_writes",   32'(n_writes - w0), 32'd1);
        check("min_addr",     32'(last_waddr),    32'd0);
        check("min_data",     last_wdata,         32'h12345678);
        check("min_core_run", 32'(core_run),      32'd1);
        check("min_load_err", 32'(load_err),      32'd0);
        check("min_rx_ready", 32'(rx_ready),      32'd0);

        // Zero count.
        apply_reset();
        q = '{8'h00, 8'h00};
        w0 = n_writes;
        send_stream(q, 1'b0);
        check("zero_load_err", 32'(load_err),      32'd1);
        check("zero_core_run", 32'(core_run),      32'd0);
        check("zero_writes",   32'(n_writes - w0), 32'd0);

        // Oversize count 2049; a following byte must not be taken.
        apply_reset();
        q = '{8'h01, 8'h08};
        w0 = n_writes;
        send_stream(q, 1'b0);
        send_byte(8'hAA, 0, 5, acc);
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        check("over_load_err", 32'(load_err),      32'd1);
        check("over_no_accept", 32'(acc),          32'd0);
        check("over_writes",   32'(n_writes - w0), 32'd0);

        // Full 2048-word load with backpressure.
        do_restart();
        check("restart_rx_ready", 32'(rx_ready), 32'd1);
        q = '{8'h00, 8'h08};
        cs = 8'd0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            w = full_word(i);
            for (int k = 0; k < 4; k++) begin
                q.push_back(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
        end
        q.push_back(cs);
        w0 = n_writes;
        send_stream(q, 1'b1);
        check("full_writes",   32'(n_writes - w0), 32'd2048);
        check("full_last_addr", 32'(last_waddr),   32'd2047);
        check("full_last_data", last_wdata,        full_word(2047));
        check("full_core_run", 32'(core_run),      32'd1);

        // Bad checksum, restart, then the correct stream.
        do_restart();
        q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        send_stream(q, 1'b0);
        check("bad_load_err", 32'(load_err), 32'd1);
        check("bad_core_run", 32'(core_run), 32'd0);
        do_restart();
        check("bad_restart_err", 32'(load_err), 32'd0);
        q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        w0 = n_writes;
        send_stream(q, 1'b0);
        check("bad_retry_run",  32'(core_run),      32'd1);
        check("bad_retry_data", last_wdata,         32'h12345678);
        check("bad_retry_wr",   32'(n_writes - w0), 32'd1);

        // Reset in the middle of the second payload word.
        do_restart();
        q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        w0 = n_writes;
        send_stream(q, 1'b0);
        check("mid_writes", 32'(n_writes - w0), 32'd1);
        check("mid_addr",   32'(last_waddr),    32'd0);
        check("mid_data",   last_wdata,         32'h44332211);
        apply_reset();
        q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        w0 = n_writes;
        send_stream(q, 1'b0);
        check("reload_writes", 32'(n_writes - w0), 32'd1);
        check("reload_addr",   32'(last_waddr),    32'd0);
        check("reload_data",   last_wdata,         32'h12345678);
        check("reload_run",    32'(core_run),      32'd1);

        repeat (3) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
